// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a 2-flop input synchronizer.
// Define UART_RX_PARITY_EN for 8E1 framing with an extra o_parity_err pulse.
module uart_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_uart_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       o_parity_err,
`endif
    output logic       o_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY    = 3'd5;
    logic       par_bit;
`endif

    logic [2:0]    state;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            o_data      <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
            par_bit      <= 1'b0;
`endif
        end else begin
            rx_m        <= i_uart_rx;
            rx_s        <= rx_m;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    // Half-period wait lands every later sample near mid-bit
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (bit_cnt == 3'd7) state <= PARITY;
`else
                        if (bit_cnt == 3'd7) state <= STOP;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == FULL) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == FULL) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (^{shift, par_bit}) begin
                                o_parity_err <= 1'b1;
                            end else begin
                                o_data  <= shift;
                                o_valid <= 1'b1;
                            end
`else
                            o_data  <= shift;
                            o_valid <= 1'b1;
`endif
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line yields a single error pulse
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, false start, break, back-to-back,
// mid-frame reset, and (with UART_RX_PARITY_EN) parity checking.
module tb_uart_rx;

    localparam int CPB  = 104;
    localparam int HALF = (CPB - 1) / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_busy;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;
    logic       par_flip = 1'b0;
    int         nperr = 0;
`endif

    int total = 0, fails = 0;
    int cyc = 0, t_fall = 0, t_valid = 0;
    int nvalid = 0, nferr = 0, viol = 0;
    logic [7:0] rxq[$];
    logic pv = 1'b0, pf = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic pp = 1'b0;
`endif

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_uart_rx   (rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(o_parity_err),
`endif
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Pulse recorder; also flags overlapping or stretched pulses
    always @(negedge clk) begin
        if (o_valid) begin
            nvalid++;
            rxq.push_back(o_data);
            t_valid = cyc;
        end
        if (o_frame_err) nferr++;
        if ((o_valid && pv) || (o_frame_err && pf)) viol++;
`ifdef UART_RX_PARITY_EN
        if (o_parity_err) nperr++;
        if (o_parity_err && pp) viol++;
        if (int'(o_valid) + int'(o_frame_err) + int'(o_parity_err) > 1) viol++;
        pp = o_parity_err;
`else
        if (o_valid && o_frame_err) viol++;
`endif
        pv = o_valid;
        pf = o_frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clk);
        rx = v;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        @(negedge clk);
        rx = 1'b0;
        t_fall = cyc;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop_v);
    endtask

    task automatic wait_idle(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!o_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int   v0, f0, lat;
        logic ok;
        logic [7:0] d96;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data",  o_data, 8'h00);
        check("rst_valid", o_valid, 1'b0);
        check("rst_ferr",  o_frame_err, 1'b0);
        check("rst_busy",  o_busy, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single frame 0x55
        v0 = nvalid;
        send_frame(8'h55, 1'b1);
        check("f55_count", nvalid - v0, 1);
        check("f55_data",  o_data, 8'h55);
        check("f55_busy",  o_busy, 1'b0);
        lat = t_valid - t_fall;
        check("f55_latency_window", {31'b0, (lat >= LAT - 1) && (lat <= LAT + 1)}, 1);

        // False start: line low 20 cycles only
        v0 = nvalid; f0 = nferr;
        @(negedge clk); rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        wait_idle(52, ok);
        check("glitch_idle",  ok, 1'b1);
        check("glitch_valid", nvalid - v0, 0);
        check("glitch_ferr",  nferr - f0, 0);

        // Framing error followed by a long break
        v0 = nvalid; f0 = nferr;
        send_frame(8'hA5, 1'b0);
        repeat (2000) @(negedge clk);
        check("break_ferr",  nferr - f0, 1);
        check("break_valid", nvalid - v0, 0);
        check("break_data",  o_data, 8'h55);
        check("break_busy",  o_busy, 1'b1);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("break_recover_busy", o_busy, 1'b0);
        send_frame(8'h3C, 1'b1);
        check("after_break_data",  o_data, 8'h3C);
        check("after_break_count", nvalid - v0, 1);

        // Back-to-back frames with one-bit stop
        v0 = nvalid;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        check("b2b_count", nvalid - v0, 3);
        check("b2b_d0", (rxq.size() >= v0 + 3) ? rxq[v0]     : 8'hxx, 8'h00);
        check("b2b_d1", (rxq.size() >= v0 + 3) ? rxq[v0 + 1] : 8'hxx, 8'hFF);
        check("b2b_d2", (rxq.size() >= v0 + 3) ? rxq[v0 + 2] : 8'hxx, 8'h81);

        // Reset in the middle of data bit 4 of 0x96
        repeat (CPB) @(negedge clk);
        v0 = nvalid; f0 = nferr;
        d96 = 8'h96;
        @(negedge clk); rx = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 4; i++) drive_bit(d96[i]);
        @(negedge clk); rx = d96[4];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_data",  o_data, 8'h00);
        check("midrst_valid", o_valid, 1'b0);
        check("midrst_ferr",  o_frame_err, 1'b0);
        check("midrst_busy",  o_busy, 1'b0);
        rst = 1'b0;
        rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("midrst_no_pulse", (nvalid - v0) + (nferr - f0), 0);
        send_frame(8'h96, 1'b1);
        check("midrst_next_data",  o_data, 8'h96);
        check("midrst_next_count", nvalid - v0, 1);

`ifdef UART_RX_PARITY_EN
        begin
            int p0;
            v0 = nvalid; p0 = nperr;
            par_flip = 1'b0;
            send_frame(8'h07, 1'b1);
            check("par_ok_count", nvalid - v0, 1);
            check("par_ok_data",  o_data, 8'h07);
            check("par_ok_perr",  nperr - p0, 0);
            par_flip = 1'b1;
            send_frame(8'h07, 1'b1);
            check("par_bad_perr",  nperr - p0, 1);
            check("par_bad_valid", nvalid - v0, 1);
            par_flip = 1'b0;
        end
`endif

        repeat (10) @(negedge clk);
        check("pulse_rules", viol, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 104, meaning i_clk cycles per serial bit (12 MHz / 115200); legal range 8..65535.
REQ-002 The block SHALL have port i_clk  input  1  sole clock; all logic is on the rising edge.
REQ-003 The block SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port i_uart_rx  input  1  asynchronous serial line, idle high.
REQ-005 The block SHALL have port o_data  output  8  last received byte, held until the next accepted frame.
REQ-006 The block SHALL have port o_valid  output  1  one-cycle pulse marking a newly accepted o_data.
REQ-007 The block SHALL have port o_frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-008 The block SHALL have port o_busy  output  1  high whenever the state is not IDLE.

Function
REQ-009 i_uart_rx SHALL pass through a 2-flop synchronizer initialised to 1; all decisions SHALL use the synchronized value (rx_s).
REQ-010 Frame format SHALL be 8N1: start bit (0), 8 data bits LSB first, stop bit (1).
REQ-011 States SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-012 IDLE: rx_s==0 SHALL load the bit counter with 0 and enter START; otherwise remain.
REQ-013 START: after (CLKS_PER_BIT-1)/2 further cycles rx_s SHALL be sampled; 0 -> DATA with bit index 0; 1 -> IDLE (false start, no output pulse).
REQ-014 DATA: each bit SHALL be sampled exactly CLKS_PER_BIT cycles after the previous sample and shifted in LSB first; after the 8th sample -> STOP.
REQ-015 STOP: sampled CLKS_PER_BIT cycles after bit 7; 1 -> o_data updated and o_valid high for exactly the next cycle, -> IDLE; 0 -> o_frame_err high for exactly one cycle, o_data unchanged, -> WAIT_IDLE.
REQ-016 WAIT_IDLE: SHALL remain until rx_s==1, then -> IDLE (break/line-low conditions produce one error pulse only).
REQ-017 o_valid and o_frame_err SHALL never be high in the same cycle, and neither SHALL be high for two consecutive cycles.
REQ-018 Back-to-back frames with a stop bit of exactly one bit period SHALL be received without loss (IDLE re-entered before next start edge's mid-point).
REQ-019 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never wrap in normal operation.
REQ-020 o_valid SHALL assert 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 cycles (±1) after the line's falling edge.

Reset
REQ-021 While i_reset is high at a clock edge: state=IDLE, synchronizer flops=1, counters=0, shift register=0, o_data=8'h00, o_valid=0, o_frame_err=0, o_busy=0.
REQ-022 Reset asserted mid-frame SHALL abandon the frame with no o_valid/o_frame_err pulse; the first full frame starting after release SHALL be received correctly.

Configuration
REQ-023 Macro UART_RX_PARITY_EN defined: frame becomes 8E1, a PARITY state is inserted between DATA and STOP sampling the parity bit CLKS_PER_BIT after bit 7, and an extra port o_parity_err output 1 pulses one cycle in place of o_valid when the XOR of data and parity bits is 1 (stop bit still checked; frame error takes precedence).
REQ-024 Macro undefined: no PARITY state, no o_parity_err port, behaviour exactly 8N1 as above.

Verification
REQ-025 Frame 0x55, CLKS_PER_BIT=104 -> single o_valid pulse, o_data=8'h55, o_busy low afterwards.
REQ-026 Line low for 20 cycles then high -> no o_valid/o_frame_err, state returns to IDLE within 52 cycles.
REQ-027 Frame 0xA5 with stop bit driven 0 then line held low 2000 cycles -> exactly one o_frame_err, no o_valid, o_data unchanged; after line high, frame 0x3C -> o_data=8'h3C.
REQ-028 Back-to-back 0x00, 0xFF, 0x81 with one-bit stop -> three o_valid pulses with those values in order.
REQ-029 i_reset pulsed during data bit 4 of 0x96 -> no pulse, all outputs at reset values; next frame 0x96 -> o_data=8'h96.
REQ-030 With UART_RX_PARITY_EN: 0x07 with parity 1 -> o_valid, o_data=8'h07; same with parity 0 -> o_parity_err only.
